// File: rtl/pipelined_alu_acc.sv
// rtl/pipelined_alu_acc.sv - runtime-opcode ALU with registered result, flags, handshake and accumulator mode
module pipelined_alu_acc #(
    parameter int             N        = 4,
    parameter logic [N-1:0]   ACC_INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic         acc_mode,
    input  logic         acc_clr,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         ovf
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_OR   = 3'd1,
        OP_SUB  = 3'd2,
        OP_XOR  = 3'd3,
        OP_AND  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic [N-1:0] result_q, result_d;
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic         ovf_q, ovf_d;
    logic         valid_q, valid_d;

    logic         accept;
    logic         consume;
    logic [N-1:0] op_a;
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N:0]   shl_ext;
    logic [N:0]   shr_ext;
    logic [N-1:0] alu_res;
    logic         alu_carry;
    logic         alu_ovf;

    // Single-entry output stage: a new op may enter whenever the slot is empty or being drained.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // In accumulator mode the registered result is operand A, so chained ops see the previous result.
    assign op_a    = acc_mode ? result_q : a;
    assign sum     = {1'b0, op_a} + {1'b0, b};
    assign diff    = {1'b0, op_a} - {1'b0, b};
    // One guard bit on each side captures the last bit shifted out (zero when the shift is zero).
    assign shl_ext = {1'b0, op_a} << b[1:0];
    assign shr_ext = {op_a, 1'b0} >> b[1:0];

    // Combinational ALU: result, carry/borrow and signed overflow for the selected opcode.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                alu_res   = sum[N-1:0];
                alu_carry = sum[N];
                alu_ovf   = (op_a[N-1] == b[N-1]) && (sum[N-1] != op_a[N-1]);
            end
            OP_OR:  alu_res = op_a | b;
            OP_SUB: begin
                alu_res   = diff[N-1:0];
                alu_carry = diff[N];
                alu_ovf   = (op_a[N-1] != b[N-1]) && (diff[N-1] != op_a[N-1]);
            end
            OP_XOR: alu_res = op_a ^ b;
            OP_AND: alu_res = op_a & b;
            OP_SHL: begin
                alu_res   = shl_ext[N-1:0];
                alu_carry = shl_ext[N];
            end
            OP_SHR: begin
                alu_res   = shr_ext[N:1];
                alu_carry = shr_ext[0];
            end
            OP_PASS: alu_res = b;
            default: alu_res = '0;
        endcase
    end

    // Next state: clear beats accept, accept beats a plain drain; otherwise everything holds.
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        if (acc_clr) begin
            result_d = ACC_INIT;
            carry_d  = 1'b0;
            zero_d   = (ACC_INIT == '0);
            ovf_d    = 1'b0;
            valid_d  = 1'b0;
        end else if (accept) begin
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            valid_d  = 1'b1;
        end else if (consume) begin
            valid_d  = 1'b0;
        end
    end

    // Result/flag/valid registers with asynchronous reset to the accumulator's initial state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= ACC_INIT;
            carry_q  <= 1'b0;
            zero_q   <= (ACC_INIT == '0);
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_pipelined_alu_acc.sv
// tb/tb_pipelined_alu_acc.sv - directed-vector and reference-model bench for pipelined_alu_acc
module tb_pipelined_alu_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic       acc_mode;
    logic       acc_clr;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       ovf;

    int nvec  = 0;
    int nfail = 0;

    pipelined_alu_acc #(.N(4), .ACC_INIT(4'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       v;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model in plain integer arithmetic; returns {result, carry, zero, ovf}.
    function automatic logic [6:0] model(input int opc, input int opa, input int opb);
        int r, c, v, sa, sb, ss, sh;
        r = 0; c = 0; v = 0;
        sa = (opa > 7) ? opa - 16 : opa;
        sb = (opb > 7) ? opb - 16 : opb;
        sh = opb % 4;
        case (opc)
            0: begin
                r = (opa + opb) & 15;
                c = (opa + opb > 15) ? 1 : 0;
                ss = sa + sb;
                v = (ss > 7 || ss < -8) ? 1 : 0;
            end
            1: r = opa | opb;
            2: begin
                r = (opa - opb) & 15;
                c = (opa < opb) ? 1 : 0;
                ss = sa - sb;
                v = (ss > 7 || ss < -8) ? 1 : 0;
            end
            3: r = opa ^ opb;
            4: r = opa & opb;
            5: begin
                r = (opa * (1 << sh)) & 15;
                c = (sh == 0) ? 0 : ((opa >> (4 - sh)) & 1);
            end
            6: begin
                r = opa >> sh;
                c = (sh == 0) ? 0 : ((opa >> (sh - 1)) & 1);
            end
            default: r = opb;
        endcase
        model = {r[3:0], c[0], (r == 0), v[0]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int         mres;
        int         opa;
        logic [6:0] exp;

        vecs[0]  = '{3'd0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd2, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd2, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'd1, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd4, 4'hC, 4'h6, 4'h4, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'd5, 4'h9, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'd5, 4'h9, 4'h4, 4'h9, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd6, 4'h9, 4'h1, 4'h4, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 4'h6, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'd7, 4'h3, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd5, 4'h3, 4'h2, 4'hC, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; acc_mode = 1'b0;
        acc_clr = 1'b0; a = 4'h0; b = 4'h0; out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_carry", int'(carry), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Single XOR op and drain
        in_valid = 1'b1; op = 3'd3; a = 4'h9; b = 4'h5; out_ready = 1'b1;
        tick();
        chk("xor_result", int'(result), 12);
        chk("xor_zero", int'(zero), 0);
        chk("xor_carry", int'(carry), 0);
        chk("xor_valid", int'(out_valid), 1);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", int'(out_valid), 0);

        // Directed vector table, back-to-back accepts
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; acc_mode = 1'b0;
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            tick();
            chk($sformatf("vec%0d_result", i), int'(result), int'(vecs[i].res));
            chk($sformatf("vec%0d_carry", i), int'(carry), int'(vecs[i].c));
            chk($sformatf("vec%0d_zero", i), int'(zero), int'(vecs[i].z));
            chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].v));
            chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
        end

        // acc_clr with a simultaneous accept: the op is discarded
        acc_clr = 1'b1; in_valid = 1'b1; op = 3'd7; b = 4'h7;
        tick();
        chk("clr_result", int'(result), 0);
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_zero", int'(zero), 1);

        // Accumulate chain: +3 four times
        acc_clr = 1'b0; acc_mode = 1'b1; op = 3'd0; b = 4'h3; a = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("acc%0d_result", i), int'(result), 3 * i);
            chk($sformatf("acc%0d_valid", i), int'(out_valid), 1);
        end

        // Backpressure: pending 0xC must hold while out_ready is low
        acc_mode = 1'b0; out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; b = 4'h5;
        #1;
        chk("bp_in_ready_low", int'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp%0d_result", i), int'(result), 12);
            chk($sformatf("bp%0d_flags", i), int'({carry, zero, ovf}), 0);
            chk($sformatf("bp%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("bp%0d_in_ready", i), int'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", int'(in_ready), 1);
        tick();
        chk("bp_new_result", int'(result), 5);
        chk("bp_new_valid", int'(out_valid), 1);

        // Asynchronous reset while a result is pending
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("hold_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_result", int'(result), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_zero", int'(zero), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);

        // Random sweep against the reference model
        mres = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            op       = 3'($urandom_range(0, 7));
            a        = 4'($urandom_range(0, 15));
            b        = 4'($urandom_range(0, 15));
            acc_mode = 1'($urandom_range(0, 1));
            opa      = acc_mode ? mres : int'(a);
            exp      = model(int'(op), opa, int'(b));
            mres     = int'(exp[6:3]);
            tick();
            chk($sformatf("rnd%0d op%0d opa%0h b%0h {res,c,z,v}", i, op, opa, b),
                int'({result, carry, zero, ovf}), int'(exp));
            chk($sformatf("rnd%0d_valid", i), int'(out_valid), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/pipelined_alu_acc.md
Name: pipelined_alu_acc

Overview:
- Sequential, runtime-configurable successor to the fixed-opcode N-bit ALU.
- Opcode is selected per operation instead of at elaboration.
- Result is registered with a valid/ready output handshake, status flags, and an accumulator mode in which the previous result replaces operand A.
- Sits between the operand-issue logic and the writeback stage of the datapath.

Parameters:
- N, 4, operand/result width in bits (N >= 2).
- ACC_INIT, 0, value loaded into the result/accumulator register on reset and on acc_clr.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  3  operation select (encoding below).
- acc_mode  in  1  1: operand A = current result register; 0: operand A = a.
- acc_clr  in  1  synchronous clear of result register to ACC_INIT.
- a  in  N  operand A.
- b  in  N  operand B.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream consumes result.
- result  out  N  registered result (doubles as accumulator).
- carry  out  1  registered carry/borrow.
- zero  out  1  registered, result == 0.
- ovf  out  1  registered signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - result=ACC_INIT, carry=0, zero=(ACC_INIT==0), ovf=0, out_valid=0.
  - in_ready=1 one settle after release; no operation accepted while rst_n=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single-entry output stage).
  - Accept when in_valid && in_ready.
  - Result, flags and out_valid=1 appear on the next rising edge (latency 1).
  - Output consumed when out_valid && out_ready; if there is no new accept that cycle, out_valid goes 0 next edge.
  - Simultaneous consume and accept: out_valid stays 1, registers take the new values (full throughput).
  - While out_valid=1 and out_ready=0: result and flags are held stable and in_ready=0.
- Operand A:
  - opA = acc_mode ? result : a.
  - The value sampled is the register value at the accept edge, so back-to-back accumulate chains use the previous result.
- Opcodes (opA, b unsigned N-bit):
  - 0 ADD: {carry,result} = opA+b; ovf = signed overflow.
  - 1 OR: result = opA|b.
  - 2 SUB: result = opA-b; carry = borrow (opA<b); ovf = signed overflow.
  - 3 XOR: result = opA^b.
  - 4 AND: result = opA&b.
  - 5 SHL: result = opA<<b[1:0]; carry = last bit shifted out (0 if shift=0).
  - 6 SHR: logical, result = opA>>b[1:0]; carry = last bit shifted out.
  - 7 PASS_B: result = b.
  - For 1, 3, 4, 7: carry=0 and ovf=0.
  - For 5, 6: ovf=0.
  - zero is computed from the new result for all ops.
- acc_clr:
  - Highest priority among synchronous actions.
  - On the edge with acc_clr=1: result=ACC_INIT, flags set as after reset, out_valid=0.
  - Any operation accepted in the same cycle is discarded.
  - in_ready is unaffected by acc_clr.
- Arithmetic wraps modulo 2^N; no saturation.
- Reset asserted mid-stream discards any pending result; no partial state survives.

Test Plan:
- Reset then single op, N=4: a=4'h9, b=4'h5, op=3, in_valid=1 for one cycle, out_ready=1 -> next edge result=4'hC, zero=0, carry=0, out_valid=1; out_valid=0 one edge later.
- ADD wrap and flags: a=4'h7, b=4'h1 -> result=4'h8, ovf=1, carry=0. Then a=4'hF, b=4'h1 -> result=4'h0, carry=1, zero=1, ovf=0.
- SUB borrow: a=4'h3, b=4'h5 -> result=4'hE, carry=1.
- Accumulate chain with acc_clr, ACC_INIT=0:
  - acc_clr pulse, then acc_mode=1, op=0, b=4'h3 accepted 4 consecutive cycles with out_ready=1.
  - Required: results 3, 6, 9, C on successive edges; out_valid high throughout.
- Backpressure: result pending, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and result/flags unchanged for all 3 cycles. Raising out_ready -> new op accepted that same cycle and its result appears next edge.
- Async reset mid-chain: drop rst_n between clock edges while out_valid=1 -> result=ACC_INIT and out_valid=0 immediately, without a clock edge.
- Random sweep: 100 random a/b/op/acc_mode accepts checked against a reference model.
